// File: rtl/tone_pkg.sv
// Shared definitions for the buzzer tone generator: note/octave codes,
// mid-octave pitch table (centi-hertz) and the FSM state type.
package tone_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_DO   = 4'd1;
  localparam logic [3:0] NOTE_RE   = 4'd2;
  localparam logic [3:0] NOTE_MI   = 4'd3;
  localparam logic [3:0] NOTE_FA   = 4'd4;
  localparam logic [3:0] NOTE_SOL  = 4'd5;
  localparam logic [3:0] NOTE_LA   = 4'd6;
  localparam logic [3:0] NOTE_SI   = 4'd7;
  localparam logic [3:0] NOTE_END  = 4'd15;

  localparam logic [1:0] OCT_LOW  = 2'd0;
  localparam logic [1:0] OCT_MID  = 2'd1;
  localparam logic [1:0] OCT_HIGH = 2'd2;
  localparam logic [1:0] OCT_ALT  = 2'd3;

  // Entry 0 is the rest slot and carries no pitch.
  localparam logic [7:0][15:0] F_CHZ = {
    16'd49388, 16'd44000, 16'd39200, 16'd34923,
    16'd32963, 16'd29366, 16'd26163, 16'd0
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    TONE = 2'd2
  } state_e;

  function automatic logic is_note(input logic [3:0] note);
    return (note >= NOTE_DO) && (note <= NOTE_SI);
  endfunction

  function automatic logic [63:0] half_period(input logic [63:0] clk_hz, input logic [2:0] idx);
    logic [63:0] f_chz;
    f_chz = {48'd0, F_CHZ[idx]};
    if (f_chz == 64'd0) begin
      return 64'd0;
    end else begin
      return (clk_hz * 64'd50) / f_chz;
    end
  endfunction

endpackage

// File: rtl/note_period_lut.sv
// Combinational half-period lookup: (note, octave) -> clock cycles per half
// period, zero for any code that does not sound.
module note_period_lut
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned CNT_W  = 20
) (
  input  logic [3:0]       note,
  input  logic [1:0]       oct,
  output logic [CNT_W-1:0] hp
);

  localparam logic [CNT_W-1:0] HP_MID [8] = '{
    CNT_W'(half_period(64'(CLK_HZ), 3'd0)),
    CNT_W'(half_period(64'(CLK_HZ), 3'd1)),
    CNT_W'(half_period(64'(CLK_HZ), 3'd2)),
    CNT_W'(half_period(64'(CLK_HZ), 3'd3)),
    CNT_W'(half_period(64'(CLK_HZ), 3'd4)),
    CNT_W'(half_period(64'(CLK_HZ), 3'd5)),
    CNT_W'(half_period(64'(CLK_HZ), 3'd6)),
    CNT_W'(half_period(64'(CLK_HZ), 3'd7))
  };

  logic [CNT_W-1:0] hp_mid_s;
  logic [CNT_W-1:0] hp_oct_s;

  // Scale the mid-octave entry by octave and blank non-sounding codes.
  always_comb begin
    hp_mid_s = HP_MID[note[2:0]];
    case (oct)
      OCT_LOW:  hp_oct_s = {hp_mid_s[CNT_W-2:0], 1'b0};
      OCT_HIGH: hp_oct_s = {1'b0, hp_mid_s[CNT_W-1:1]};
      default:  hp_oct_s = hp_mid_s;
    endcase
    if (is_note(note)) begin
      hp = hp_oct_s;
    end else begin
      hp = {CNT_W{1'b0}};
    end
  end

endmodule

// File: rtl/buzzer_tone_gen.sv
// Square-wave buzzer driver: IDLE/GAP/TONE FSM with a silent articulation
// gap on every note or octave change.
module buzzer_tone_gen
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned GAP_CYCLES = 2000000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] note_in,
  input  logic [1:0] octave_in,
  output logic       buzzer,
  output logic       active
);

  // The shared counter must also hold the gap length, which can exceed CNT_W.
  localparam int unsigned GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam int unsigned CW       = (GAP_W > CNT_W) ? GAP_W : CNT_W;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES == 0) ? {CW{1'b0}} : CW'(GAP_CYCLES - 1);
  localparam state_e ENTRY_STATE     = (GAP_CYCLES == 0) ? TONE : GAP;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             buzzer_q, buzzer_d;
  logic             active_q, active_d;
  logic [3:0]       note_q;
  logic [1:0]       oct_q;

  logic [CNT_W-1:0] hp_s;
  logic [CW-1:0]    hp_last_s;
  logic             change_s;
  logic             new_sounding_s;
  logic             held_sounding_s;

  note_period_lut #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) u_lut (
    .note (note_q),
    .oct  (oct_q),
    .hp   (hp_s)
  );

  assign hp_last_s       = CW'(hp_s) - CNT_ONE;
  assign change_s        = {note_in, octave_in} != {note_q, oct_q};
  assign new_sounding_s  = enable && is_note(note_in);
  assign held_sounding_s = enable && is_note(note_q);

  // Next-state logic; mute overrides everything, then change detection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buzzer_d = buzzer_q;
    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = CNT_ZERO;
      buzzer_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d    = CNT_ZERO;
          buzzer_d = 1'b0;
          if (change_s) begin
            state_d = new_sounding_s ? ENTRY_STATE : IDLE;
          end else if (held_sounding_s) begin
            state_d = TONE;
          end else begin
            state_d = IDLE;
          end
        end
        GAP: begin
          buzzer_d = 1'b0;
          if (change_s) begin
            cnt_d   = CNT_ZERO;
            state_d = GAP;
          end else if (cnt_q >= GAP_LAST) begin
            cnt_d   = CNT_ZERO;
            state_d = held_sounding_s ? TONE : IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            state_d = GAP;
          end
        end
        TONE: begin
          if (change_s) begin
            cnt_d    = CNT_ZERO;
            buzzer_d = 1'b0;
            state_d  = new_sounding_s ? ENTRY_STATE : IDLE;
          end else if (!held_sounding_s) begin
            cnt_d    = CNT_ZERO;
            buzzer_d = 1'b0;
            state_d  = IDLE;
          end else if (cnt_q >= hp_last_s) begin
            cnt_d    = CNT_ZERO;
            buzzer_d = ~buzzer_q;
            state_d  = TONE;
          end else begin
            cnt_d    = cnt_q + CNT_ONE;
            state_d  = TONE;
          end
        end
        default: begin
          state_d  = IDLE;
          cnt_d    = CNT_ZERO;
          buzzer_d = 1'b0;
        end
      endcase
    end
    active_d = (state_d == TONE);
  end

  // State, counter, registered outputs and input capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ZERO;
      buzzer_q <= 1'b0;
      active_q <= 1'b0;
      note_q   <= NOTE_REST;
      oct_q    <= OCT_LOW;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buzzer_q <= buzzer_d;
      active_q <= active_d;
      note_q   <= note_in;
      oct_q    <= octave_in;
    end
  end

  assign buzzer = buzzer_q;
  assign active = active_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench: dut_a uses a scaled clock (HP = default/1000) with a
// 200-cycle gap, dut_b the same clock with the gap disabled.
module tb_buzzer_tone_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_a, en_b;
  logic [3:0] note_a, note_b;
  logic [1:0] oct_a, oct_b;
  logic       buz_a, buz_b, act_a, act_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  buzzer_tone_gen #(.CLK_HZ(100000), .GAP_CYCLES(200), .CNT_W(12)) dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .note_in(note_a), .octave_in(oct_a),
    .buzzer(buz_a), .active(act_a)
  );

  buzzer_tone_gen #(.CLK_HZ(100000), .GAP_CYCLES(0), .CNT_W(12)) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .note_in(note_b), .octave_in(oct_b),
    .buzzer(buz_b), .active(act_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return buz_a;
      1:       return act_a;
      2:       return buz_b;
      default: return act_b;
    endcase
  endfunction

  // Edges until the selected output equals target; -1 if the budget expires.
  task automatic wait_for(input int sel, input logic target, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (probe(sel) === target) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en_a = 1'b0; note_a = 4'd0; oct_a = 2'd1;
    en_b = 1'b0; note_b = 4'd0; oct_b = 2'd1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1;
    en_a = 1'b1; note_a = 4'd6; oct_a = 2'd1;
    en_b = 1'b1; note_b = 4'd6; oct_b = 2'd1;
    step();
    step();
    tests++; if ({buz_a, act_a} !== 2'b00) begin fails++; $display("FAIL reset_a: got buz/act=%b required 00", {buz_a, act_a}); end
    tests++; if ({buz_b, act_b} !== 2'b00) begin fails++; $display("FAIL reset_b: got buz/act=%b required 00", {buz_b, act_b}); end
    bad = 0;
    repeat (300) begin
      step();
      if ({buz_a, act_a, buz_b, act_b} !== 4'b0000) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL reset_hold: got %0d active cycles required 0", bad); end
    do_reset();
  endtask

  task automatic test_basic_tone();
    int n, n_lo, n_hi;
    do_reset();
    en_a = 1'b1; note_a = 4'd6; oct_a = 2'd1;
    wait_for(1, 1'b1, 400, n);
    tests++; if (n !== 201) begin fails++; $display("FAIL a_gap_len: got %0d required 201", n); end
    tests++; if (buz_a !== 1'b0) begin fails++; $display("FAIL a_silent_entry: got %b required 0", buz_a); end
    wait_for(0, 1'b1, 400, n);
    tests++; if (n !== 113) begin fails++; $display("FAIL a_first_rise: got %0d required 113", n); end
    wait_for(0, 1'b0, 400, n_hi);
    wait_for(0, 1'b1, 400, n_lo);
    tests++; if (n_hi !== 113) begin fails++; $display("FAIL a_half_hi: got %0d required 113", n_hi); end
    tests++; if (n_hi + n_lo !== 226) begin fails++; $display("FAIL a_period: got %0d required 226", n_hi + n_lo); end
  endtask

  task automatic test_octaves();
    int n;
    do_reset();
    en_b = 1'b1; note_b = 4'd6; oct_b = 2'd0;
    wait_for(3, 1'b1, 10, n);
    tests++; if (n !== 1) begin fails++; $display("FAIL b_direct_tone: got %0d required 1", n); end
    wait_for(2, 1'b1, 600, n);
    tests++; if (n !== 226) begin fails++; $display("FAIL b_low_rise: got %0d required 226", n); end
    wait_for(2, 1'b0, 600, n);
    tests++; if (n !== 226) begin fails++; $display("FAIL b_low_half: got %0d required 226", n); end
    oct_b = 2'd2;
    wait_for(2, 1'b1, 300, n);
    tests++; if (n !== 57) begin fails++; $display("FAIL b_high_rise: got %0d required 57", n); end
    wait_for(2, 1'b0, 300, n);
    tests++; if (n !== 56) begin fails++; $display("FAIL b_high_half: got %0d required 56", n); end
    oct_b = 2'd3;
    wait_for(2, 1'b1, 300, n);
    tests++; if (n !== 114) begin fails++; $display("FAIL b_oct3_rise: got %0d required 114", n); end
    wait_for(2, 1'b0, 300, n);
    tests++; if (n !== 113) begin fails++; $display("FAIL b_oct3_half: got %0d required 113", n); end
    en_b = 1'b0;
  endtask

  task automatic test_rest_codes();
    int n, bad;
    do_reset();
    en_a = 1'b1; note_a = 4'd1; oct_a = 2'd1;
    wait_for(1, 1'b1, 400, n);
    wait_for(0, 1'b1, 400, n);
    tests++; if (n !== 191) begin fails++; $display("FAIL c_rise_do: got %0d required 191", n); end
    note_a = 4'd0;
    step();
    step();
    tests++; if ({buz_a, act_a} !== 2'b00) begin fails++; $display("FAIL c_rest_mute: got buz/act=%b required 00", {buz_a, act_a}); end
    note_a = 4'd15;
    bad = 0;
    repeat (400) begin step(); if ({buz_a, act_a} !== 2'b00) bad++; end
    tests++; if (bad !== 0) begin fails++; $display("FAIL c_end_code: got %0d sounding cycles required 0", bad); end
    note_a = 4'd9;
    bad = 0;
    repeat (400) begin step(); if ({buz_a, act_a} !== 2'b00) bad++; end
    tests++; if (bad !== 0) begin fails++; $display("FAIL c_invalid_code: got %0d sounding cycles required 0", bad); end
    tests++; if (dut_a.state_q !== tone_pkg::IDLE) begin fails++; $display("FAIL c_idle_state: got %0d required %0d", dut_a.state_q, tone_pkg::IDLE); end
  endtask

  task automatic test_note_change();
    int n;
    do_reset();
    en_a = 1'b1; note_a = 4'd5; oct_a = 2'd1;
    wait_for(1, 1'b1, 400, n);
    wait_for(0, 1'b1, 400, n);
    tests++; if (n !== 127) begin fails++; $display("FAIL d_rise_sol: got %0d required 127", n); end
    note_a = 4'd3;
    step();
    tests++; if ({buz_a, act_a} !== 2'b00) begin fails++; $display("FAIL d_gap_mute: got buz/act=%b required 00", {buz_a, act_a}); end
    wait_for(1, 1'b1, 400, n);
    tests++; if (n !== 200) begin fails++; $display("FAIL d_gap_len: got %0d required 200", n); end
    wait_for(0, 1'b1, 400, n);
    tests++; if (n !== 151) begin fails++; $display("FAIL d_rise_mi: got %0d required 151", n); end
    wait_for(0, 1'b0, 400, n);
    tests++; if (n !== 151) begin fails++; $display("FAIL d_half_mi: got %0d required 151", n); end
    note_a = 4'd5;
    repeat (50) step();
    tests++; if (act_a !== 1'b0) begin fails++; $display("FAIL d_mid_gap: got active=%b required 0", act_a); end
    note_a = 4'd7;
    wait_for(1, 1'b1, 400, n);
    tests++; if (n !== 201) begin fails++; $display("FAIL d_gap_restart: got %0d required 201", n); end
    wait_for(0, 1'b1, 400, n);
    tests++; if (n !== 101) begin fails++; $display("FAIL d_rise_si: got %0d required 101", n); end
  endtask

  task automatic test_enable();
    int n;
    do_reset();
    en_a = 1'b1; note_a = 4'd7; oct_a = 2'd1;
    wait_for(1, 1'b1, 400, n);
    wait_for(0, 1'b1, 400, n);
    en_a = 1'b0;
    step();
    tests++; if ({buz_a, act_a} !== 2'b00) begin fails++; $display("FAIL e_mute: got buz/act=%b required 00", {buz_a, act_a}); end
    repeat (5) step();
    en_a = 1'b1;
    wait_for(1, 1'b1, 400, n);
    tests++; if (n !== 1) begin fails++; $display("FAIL e_no_gap: got %0d required 1", n); end
    wait_for(0, 1'b1, 400, n);
    tests++; if (n !== 101) begin fails++; $display("FAIL e_rise_reenable: got %0d required 101", n); end
    note_a = 4'd7; oct_a = 2'd1;
    wait_for(0, 1'b0, 400, n);
    tests++; if (n !== 101) begin fails++; $display("FAIL e_same_note: got %0d required 101", n); end
  endtask

  task automatic test_reset_mid_tone();
    int n;
    do_reset();
    en_a = 1'b1; note_a = 4'd7; oct_a = 2'd1;
    wait_for(1, 1'b1, 400, n);
    wait_for(0, 1'b1, 400, n);
    reset = 1'b1;
    step();
    tests++; if ({buz_a, act_a} !== 2'b00) begin fails++; $display("FAIL f_reset_mid: got buz/act=%b required 00", {buz_a, act_a}); end
    reset = 1'b0;
    wait_for(1, 1'b1, 400, n);
    tests++; if (n !== 201) begin fails++; $display("FAIL f_reentry_gap: got %0d required 201", n); end
    wait_for(0, 1'b1, 400, n);
    tests++; if (n !== 101) begin fails++; $display("FAIL f_reentry_rise: got %0d required 101", n); end
  endtask

  initial begin
    test_reset();
    test_basic_tone();
    test_octaves();
    test_rest_codes();
    test_note_change();
    test_enable();
    test_reset_mid_tone();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
